// File: rtl/mixcol_iter.sv
// mixcol_iter: iterative AES (Inv)MixColumns, one column per clock,
// with a last-round bypass that forwards the state unchanged.
module mixcol_iter #(
  parameter bit INV = 1'b0
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);
  localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2;
  localparam logic [3:0] K0 = INV ? 4'he : 4'h2;
  localparam logic [3:0] K1 = INV ? 4'hb : 4'h3;
  localparam logic [3:0] K2 = INV ? 4'hd : 4'h1;
  localparam logic [3:0] K3 = INV ? 4'h9 : 4'h1;
  logic [1:0]   state, col;
  logic [127:0] work, nxt;
  logic [31:0]  a, b;
  logic         accept;

  function automatic logic [7:0] xt(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
  endfunction

  // k is always a constant, so each product collapses to an xtime chain and XORs
  function automatic logic [7:0] mul(input logic [7:0] v, input logic [3:0] k);
    logic [7:0] v2, v4, v8;
    v2 = xt(v);
    v4 = xt(v2);
    v8 = xt(v4);
    return (k[0] ? v : 8'h00) ^ (k[1] ? v2 : 8'h00) ^ (k[2] ? v4 : 8'h00) ^ (k[3] ? v8 : 8'h00);
  endfunction

  assign in_ready  = (state == IDLE) || (state == DONE && out_ready);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;

  always_comb begin
    a = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (2'(c) == col) a[31-8*r -: 8] = work[127-32*r-8*c -: 8];
    for (int i = 0; i < 4; i++)
      b[31-8*i -: 8] = mul(a[31-8*i -: 8], K0) ^ mul(a[31-8*((i+1)%4) -: 8], K1)
                     ^ mul(a[31-8*((i+2)%4) -: 8], K2) ^ mul(a[31-8*((i+3)%4) -: 8], K3);
    nxt = work;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (2'(c) == col) nxt[127-32*r-8*c -: 8] = b[31-8*r -: 8];
  end

  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      state    <= IDLE;
      col      <= '0;
      work     <= '0;
      out_data <= '0;
    end else if (accept) begin
      state <= in_last ? DONE : BUSY;
      col   <= '0;
      if (in_last) out_data <= in_data;
      else work <= in_data;
    end else if (state == BUSY) begin
      work <= nxt;
      col  <= col + 2'd1;
      if (col == 2'd3) begin
        state    <= DONE;
        out_data <= nxt;
      end
    end else if (state == DONE && out_ready) state <= IDLE;
endmodule

// File: tb/tb_mixcol_iter.sv
// tb_mixcol_iter: directed and stream checks of mixcol_iter in forward and inverse builds.
module tb_mixcol_iter;
  logic         clock = 1'b0, resetn = 1'b1;
  logic         in_valid [2], in_ready [2], in_last [2], out_valid [2], out_ready [2];
  logic [127:0] in_data [2], out_data [2];
  int           n_chk = 0, n_fail = 0;

  mixcol_iter #(.INV(1'b0)) u_fwd (
    .clock(clock), .resetn(resetn), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .in_last(in_last[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_data(out_data[0])
  );
  mixcol_iter #(.INV(1'b1)) u_inv (
    .clock(clock), .resetn(resetn), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .in_last(in_last[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_data(out_data[1])
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p, aa, bb;
    p = 8'h00;
    aa = x;
    bb = y;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p ^= aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] s, input bit inv);
    logic [7:0] k [4];
    logic [7:0] acc;
    logic [127:0] o;
    k = inv ? '{8'h0e, 8'h0b, 8'h0d, 8'h09} : '{8'h02, 8'h03, 8'h01, 8'h01};
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int i = 0; i < 4; i++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) acc ^= gmul(k[(j-i+4)%4], s[127-32*j-8*c -: 8]);
        o[127-32*i-8*c -: 8] = acc;
      end
    return o;
  endfunction

  // columns are given top byte first; state is stored row-major
  function automatic logic [127:0] cols(input logic [31:0] c0, c1, c2, c3);
    logic [31:0] cc [4];
    logic [127:0] st;
    cc = '{c0, c1, c2, c3};
    st = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) st[127-32*r-8*c -: 8] = cc[c][31-8*r -: 8];
    return st;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run(input int u, input logic [127:0] d, input logic last,
                     output logic [127:0] r, output int lat);
    chk("ready_before_send", 128'(in_ready[u]), 128'd1);
    in_valid[u] = 1'b1;
    in_data[u]  = d;
    in_last[u]  = last;
    step();
    in_valid[u] = 1'b0;
    in_last[u]  = 1'b0;
    lat = 0;
    while (!out_valid[u] && lat < 20) begin
      step();
      lat++;
    end
    r = out_data[u];
    out_ready[u] = 1'b1;
    step();
    out_ready[u] = 1'b0;
  endtask

  logic [127:0] f_in, f_out, bp, d2, r, y, x, held;
  int lat;

  initial begin
    for (int u = 0; u < 2; u++) begin
      in_valid[u] = 1'b0; in_last[u] = 1'b0; out_ready[u] = 1'b0; in_data[u] = '0;
    end
    f_in  = cols(32'hdb135345, 32'hf20a225c, 32'h01010101, 32'hc6c6c6c6);
    f_out = cols(32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6);
    #1 resetn = 1'b0;
    #1;
    chk("rst_out_valid", 128'(out_valid[0]), 128'd0);
    chk("rst_out_data", out_data[0], 128'd0);
    chk("rst_in_ready", 128'(in_ready[0]), 128'd1);
    chk("rst_inv_out_data", out_data[1], 128'd0);
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    step();
    run(0, f_in, 1'b0, r, lat);
    chk("fwd_data", r, f_out);
    chk("fwd_latency", 128'(lat), 128'd4);
    chk("fwd_retired", 128'(out_valid[0]), 128'd0);
    run(1, f_out, 1'b0, r, lat);
    chk("inv_data", r, f_in);
    chk("inv_latency", 128'(lat), 128'd4);
    for (int i = 0; i < 100; i++) begin
      x = {$urandom, $urandom, $urandom, $urandom};
      run(0, x, 1'b0, y, lat);
      chk("rt_fwd", y, model(x, 1'b0));
      run(1, y, 1'b0, r, lat);
      chk("rt_identity", r, x);
    end
    bp = 128'h00112233445566778899aabbccddeeff;
    in_valid[0] = 1'b1; in_last[0] = 1'b1; in_data[0] = bp;
    step();
    in_valid[0] = 1'b0; in_last[0] = 1'b0;
    chk("byp_valid", 128'(out_valid[0]), 128'd1);
    chk("byp_data", out_data[0], bp);
    chk("byp_in_ready", 128'(in_ready[0]), 128'd0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_data", out_data[0], bp);
      chk("bp_valid", 128'(out_valid[0]), 128'd1);
      chk("bp_in_ready", 128'(in_ready[0]), 128'd0);
    end
    d2 = cols(32'hd4bf5d30, 32'he0b452ae, 32'hb84111f1, 32'h1e2798e5);
    out_ready[0] = 1'b1; in_valid[0] = 1'b1; in_data[0] = d2;
    #1;
    chk("b2b_in_ready", 128'(in_ready[0]), 128'd1);
    step();
    in_valid[0] = 1'b0; out_ready[0] = 1'b0;
    chk("b2b_busy", 128'(out_valid[0]), 128'd0);
    chk("b2b_hold", out_data[0], bp);
    lat = 0;
    while (!out_valid[0] && lat < 20) begin
      step();
      lat++;
    end
    chk("b2b_latency", 128'(lat), 128'd4);
    chk("b2b_data", out_data[0], cols(32'h046681e5, 32'he0cb199a, 32'h48f8d37a, 32'h2806264c));
    out_ready[0] = 1'b1;
    step();
    out_ready[0] = 1'b0;
    chk("b2b_no_dup", 128'(out_valid[0]), 128'd0);
    held = out_data[0];
    in_valid[0] = 1'b1; in_data[0] = {4{32'hdeadbeef}};
    step();
    in_valid[0] = 1'b0;
    step();
    step();
    #2 resetn = 1'b0;
    #1;
    chk("arst_out_valid", 128'(out_valid[0]), 128'd0);
    chk("arst_out_data", out_data[0], 128'd0);
    chk("arst_in_ready", 128'(in_ready[0]), 128'd1);
    chk("arst_prior_nonzero", 128'(held != '0), 128'd1);
    @(negedge clock);
    resetn = 1'b1;
    step();
    chk("post_rst_idle", 128'(out_valid[0]), 128'd0);
    run(0, f_in, 1'b0, r, lat);
    chk("post_rst_data", r, f_out);
    chk("post_rst_latency", 128'(lat), 128'd4);
    begin
      logic [127:0] q [$];
      logic [127:0] e;
      int sent, acc_n, ret_n, cyc;
      logic pend;
      sent = 0; acc_n = 0; ret_n = 0; cyc = 0; pend = 1'b0;
      while ((sent < 40 || pend || q.size() != 0) && cyc < 5000) begin
        out_ready[0] = ($urandom_range(0, 3) != 0);
        if (!pend && sent < 40 && $urandom_range(0, 2) != 0) begin
          in_data[0]  = {$urandom, $urandom, $urandom, $urandom};
          in_last[0]  = ($urandom_range(0, 3) == 0);
          in_valid[0] = 1'b1;
          pend = 1'b1;
          sent++;
        end
        #1;
        if (out_valid[0] && out_ready[0]) begin
          e = (q.size() != 0) ? q.pop_front() : 'x;
          chk("stream_data", out_data[0], e);
          ret_n++;
        end
        if (in_valid[0] && in_ready[0]) begin
          q.push_back(in_last[0] ? in_data[0] : model(in_data[0], 1'b0));
          acc_n++;
          pend = 1'b0;
        end
        step();
        if (!pend) in_valid[0] = 1'b0;
        cyc++;
      end
      out_ready[0] = 1'b0;
      chk("stream_accepted", 128'(acc_n), 128'd40);
      chk("stream_retired", 128'(ret_n), 128'd40);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
